// File: rtl/pwm_capture_pkg.sv
// Shared types and defaults for the PWM capture block.
package pwm_capture_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_STUCK = 2'd3
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous input, with a one-cycle-delayed
// copy for rise/fall detection. Usable for any slow external input.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev   <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rise-to-rise period of a PWM input in clock cycles,
// strobing valid per complete period and flagging a missing edge as stuck.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] duty,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             stuck,
    output logic             level
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             rise;
    logic             fall;
    state_t           state, state_n;
    logic [CNT_W-1:0] pcnt, pcnt_n;
    logic [CNT_W-1:0] hcnt, hcnt_n;
    logic             meas_done;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk   (clk),
        .rst   (rst),
        .din   (pwm_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            pcnt   <= '0;
            hcnt   <= '0;
            duty   <= '0;
            period <= '0;
            valid  <= 1'b0;
        end else begin
            state <= state_n;
            pcnt  <= pcnt_n;
            hcnt  <= hcnt_n;
            valid <= meas_done;
            if (meas_done) begin
                duty   <= hcnt;
                period <= pcnt;
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        state_n   = state;
        pcnt_n    = pcnt;
        hcnt_n    = hcnt;
        meas_done = 1'b0;
        case (state)
            ST_IDLE, ST_STUCK: begin
                if (rise) begin
                    state_n = ST_HIGH;
                    pcnt_n  = CNT_ONE;
                    hcnt_n  = CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (pcnt == CNT_MAX) begin
                    state_n = ST_STUCK;
                end else if (fall) begin
                    state_n = ST_LOW;
                    pcnt_n  = pcnt + CNT_ONE;
                end else begin
                    pcnt_n = pcnt + CNT_ONE;
                    hcnt_n = hcnt + CNT_ONE;
                end
            end
            ST_LOW: begin
                // A rise on the saturating cycle still closes a valid period.
                if (rise) begin
                    meas_done = 1'b1;
                    state_n   = ST_HIGH;
                    pcnt_n    = CNT_ONE;
                    hcnt_n    = CNT_ONE;
                end else if (pcnt == CNT_MAX) begin
                    state_n = ST_STUCK;
                end else begin
                    pcnt_n = pcnt + CNT_ONE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        stuck = (state == ST_STUCK);
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: drives hi/lo pulse trains and checks
// each valid strobe against expectations queued when the pulses are driven.
module tb_pwm_capture;

    localparam int CNT_W = 8;

    typedef struct {
        int unsigned duty;
        int unsigned period;
    } meas_t;

    logic             clk;
    logic             rst;
    logic             pwm_in;
    logic [CNT_W-1:0] duty;
    logic [CNT_W-1:0] period;
    logic             valid;
    logic             stuck;
    logic             level;

    int n_checks = 0;
    int n_fail   = 0;

    meas_t sb[$];
    meas_t m;
    bit    have_prev  = 1'b0;
    int    prev_hi    = 0;
    int    prev_lo    = 0;
    bit    prev_valid = 1'b0;
    bit    stuck_seen = 1'b0;

    pwm_capture #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .duty   (duty),
        .period (period),
        .valid  (valid),
        .stuck  (stuck),
        .level  (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one pulse; its rising edge closes the previous pulse's period.
    task automatic drive_pulse(input int hi, input int lo);
        meas_t e;
        if (have_prev) begin
            e.duty   = prev_hi;
            e.period = prev_hi + prev_lo;
            sb.push_back(e);
        end
        pwm_in = 1'b1;
        repeat (hi) @(posedge clk);
        #1;
        pwm_in = 1'b0;
        repeat (lo) @(posedge clk);
        #1;
        have_prev = 1'b1;
        prev_hi   = hi;
        prev_lo   = lo;
    endtask

    always @(negedge clk) begin
        if (valid) begin
            check("valid_b2b", prev_valid, 0);
            if (sb.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                m = sb.pop_front();
                check("duty", duty, m.duty);
                check("period", period, m.period);
            end
        end
        if (stuck) stuck_seen = 1'b1;
        prev_valid = valid;
    end

    initial begin
        meas_t e;
        rst    = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_duty", duty, 0);
        check("rst_period", period, 0);
        check("rst_valid", valid, 0);
        check("rst_stuck", stuck, 0);
        check("rst_level", level, 0);

        // Steady 3/7, then 1/1 minimum-width stream.
        stuck_seen = 1'b0;
        repeat (6) drive_pulse(3, 7);
        repeat (8) drive_pulse(1, 1);
        check("stuck_1_1", stuck_seen, 0);

        // Hold high 300 cycles: stuck appears 256 cycles after the rise at s.
        e.duty   = prev_hi;
        e.period = prev_hi + prev_lo;
        sb.push_back(e);
        pwm_in = 1'b1;
        repeat (257) @(posedge clk);
        @(negedge clk);
        check("stuck_pre", stuck, 0);
        @(posedge clk);
        @(negedge clk);
        check("stuck_set", stuck, 1);
        repeat (42) @(posedge clk);
        #1;
        check("stuck_level", level, 1);
        check("stuck_duty", duty, 1);
        check("stuck_period", period, 2);
        check("stuck_hold", stuck, 1);
        check("stuck_sb", sb.size(), 0);
        pwm_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        have_prev = 1'b0;

        // Rise out of stuck: no valid, stuck cleared; next rise measures.
        drive_pulse(4, 6);
        check("stuck_clear", stuck, 0);
        stuck_seen = 1'b0;
        drive_pulse(4, 6);

        // Period exactly 255 is measurable; 256 saturates.
        drive_pulse(100, 155);
        drive_pulse(100, 155);
        drive_pulse(100, 156);
        check("p255_no_stuck", stuck_seen, 0);
        repeat (4) @(posedge clk);
        #1;
        check("p256_stuck", stuck, 1);
        check("p256_period", period, 255);
        have_prev = 1'b0;

        // Reset mid-LOW discards the partial period.
        repeat (3) drive_pulse(3, 7);
        drive_pulse(3, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_duty", duty, 0);
        check("mid_rst_period", period, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_stuck", stuck, 0);
        check("mid_rst_level", level, 0);
        have_prev = 1'b0;
        repeat (3) drive_pulse(3, 7);

        // Duty change on the fly: 2/8 then 6/4.
        repeat (3) drive_pulse(2, 8);
        repeat (4) drive_pulse(6, 4);
        drive_pulse(2, 2);
        repeat (6) @(posedge clk);
        #1;
        check("drain", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming pulse-width-modulated signal and reports its high time and period in clock cycles. It is the receive side of the board's PWM LED drive: it sits at an external input pin, typically a loopback of an LED drive line or an external PWM source, and feeds status and self-test logic. The input is synchronised, edge-detected and timed by a small FSM. A one-cycle `valid` strobe accompanies each completed measurement, and `stuck` flags a missing edge.

## Interface
- `CNT_W`, 8, width of the duty and period counters; maximum measurable period is 2^CNT_W−1 cycles.
- `SYNC_STAGES`, 2, flops in the input synchroniser (≥2).

- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  reset; one clock, reset is synchronous and active-high.
- `pwm_in`  in  1  asynchronous PWM input.
- `duty`  out  CNT_W  high-time of last complete period, in cycles.
- `period`  out  CNT_W  rise-to-rise time of last complete period, in cycles.
- `valid`  out  1  one-cycle strobe when `duty`/`period` update.
- `stuck`  out  1  no rising edge seen for 2^CNT_W−1 cycles.
- `level`  out  1  synchronised input level (last synchroniser stage).

## Operation
- Synchroniser: `pwm_in` passes through SYNC_STAGES flops, giving `s`. `prev` is `s` delayed by one cycle. `rise` = s & ~prev and `fall` = ~s & prev, both combinational.
- Counters: `pcnt` and `hcnt`, each CNT_W bits wide and unsigned.
- FSM states:
  - IDLE: on `rise`, go to HIGH with pcnt=1, hcnt=1.
  - HIGH: each cycle pcnt+1, hcnt+1. On `fall`, go to LOW; the fall cycle gives pcnt+1 and leaves hcnt unchanged.
  - LOW: each cycle pcnt+1. On `rise`, latch duty←hcnt, period←pcnt, assert valid for one cycle, set pcnt=1, hcnt=1, and go to HIGH.
  - STUCK: `stuck`=1. On `rise`, go to HIGH with pcnt=1, hcnt=1 and clear stuck; no valid is issued for this rise.
- Saturation: in HIGH or LOW, when pcnt equals all-ones and the current cycle is not a rise, go to STUCK next cycle. The counters hold and `duty`/`period` keep their last values. This covers 0 % and 100 % duty and a dead input.
- First rise after reset or after STUCK never produces `valid`, because no complete period exists yet.
- Simultaneous rise and saturation: the rise wins. The period is latched as 2^CNT_W−1 with valid, and no transition to STUCK occurs.
- Reset mid-measurement: everything returns to reset values and any partial period is discarded.
- Widths: a valid measurement always satisfies 1 ≤ duty < period ≤ 2^CNT_W−1. No counter wraps.

## Timing
- Reset values:
  - duty=0, period=0, valid=0, stuck=0, level=0
  - synchroniser=0, prev=0
  - FSM=IDLE, pcnt=hcnt=0
- A `pwm_in` change sampled at edge k appears on `level` after edge k+SYNC_STAGES−1.
- `valid`, `duty` and `period` update at the edge after `rise` is seen. For SYNC_STAGES=2, that is edge k+2.
- `stuck` asserts at the edge after pcnt reaches all-ones. It deasserts at the edge after the next `rise`.
- Minimum resolvable input: 1 cycle high and 1 cycle low (period 2), measured at `s`.
- `valid` is never high on two consecutive cycles.

## Structure
- Shared package:
  - FSM state typedef/encoding (IDLE, HIGH, LOW, STUCK)
  - default CNT_W constant
- Sub-module `sync_edge`: parameterised SYNC_STAGES synchroniser plus `prev` register. It outputs `level`, `rise` and `fall` and is reusable for buttons and other external inputs.
- The top level holds the FSM, the counters and the output registers only.

## Test plan
- CNT_W=8 with a steady input of 3 high / 7 low, repeated. The first rise gives no valid; every later rise gives valid with duty=3, period=10, and valid is never back-to-back.
- 1 high / 1 low input: duty=1, period=2 on every valid, and stuck stays 0.
- Input held high for 300 cycles after one rise: stuck=1 at pcnt=255, no valid, level=1, duty/period unchanged. The next rise clears stuck with no valid; the following rise yields a correct measurement.
- Period exactly 255 (100 high / 155 low): valid with duty=100, period=255 and no stuck. Period 256 instead goes to STUCK.
- Reset asserted mid-LOW during a 3/7 stream: all outputs are 0 the cycle after reset. The first rise after reset gives no valid; the second gives duty=3, period=10.
- Duty change from 2/8 to 6/4 on the fly: the period spanning the switch reports the actual cycles counted, then duty=6, period=10 steadily.
